// File: rtl/ir_pkg.sv
// Shared NEC decoder types and pulse-width windows, all widths in microseconds.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LOW,
    LEAD_HIGH,
    BIT_LOW,
    BIT_HIGH,
    REP_STOP
  } nec_state_t;

  localparam logic [15:0] LEAD_LOW_MIN  = 16'd8000;
  localparam logic [15:0] LEAD_LOW_MAX  = 16'd10000;
  localparam logic [15:0] LEAD_HIGH_MIN = 16'd4000;
  localparam logic [15:0] LEAD_HIGH_MAX = 16'd5000;
  localparam logic [15:0] REP_HIGH_MIN  = 16'd2000;
  localparam logic [15:0] REP_HIGH_MAX  = 16'd2500;
  localparam logic [15:0] BURST_MIN     = 16'd400;
  localparam logic [15:0] BURST_MAX     = 16'd700;
  localparam logic [15:0] ZERO_MIN      = 16'd400;
  localparam logic [15:0] ZERO_MAX      = 16'd700;
  localparam logic [15:0] ONE_MIN       = 16'd1400;
  localparam logic [15:0] ONE_MAX       = 16'd1900;
  localparam logic [15:0] TIMEOUT_US    = 16'd10000;

  localparam logic [5:0]  FRAME_BITS    = 6'd32;

  function automatic logic in_window(input logic [15:0] w,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_edge_timer.sv
// Synchronises the IR line, detects edges and measures the time since the last
// edge in microseconds.
module ir_edge_timer #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_in,
  output logic        fall,
  output logic        rise,
  output logic [15:0] width_us
);

  localparam int unsigned DIV = CLK_HZ / 1_000_000;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic          sync1_q, sync2_q, prev_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   width_q, width_d;
  logic          tick;

  assign fall     = prev_q & ~sync2_q;
  assign rise     = ~prev_q & sync2_q;
  assign tick     = (pre_q == PW'(DIV - 1));
  assign width_us = width_q;

  always_comb begin
    pre_d   = tick ? '0 : pre_q + 1'b1;
    width_d = width_q;
    // A tick coinciding with the edge belongs to the new interval, so an
    // interval of N us reads back as exactly N at the next edge.
    if (fall || rise) begin
      width_d = tick ? 16'd1 : 16'd0;
    end else if (tick && (width_q != '1)) begin
      width_d = width_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      pre_q   <= '0;
      width_q <= '0;
    end else begin
      sync1_q <= ir_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pre_q   <= pre_d;
      width_q <= width_d;
    end
  end

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: classifies measured pulse widths, assembles the 32-bit
// frame LSB first and emits single-cycle ready/repeat/error strobes.
module nec_ir_decoder
  import ir_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_in,
  output logic [31:0] ir_data,
  output logic        data_ready,
  output logic        repeat_ready,
  output logic        frame_error
);

  logic        fall, rise;
  logic [15:0] width_us;

  ir_edge_timer #(
    .CLK_HZ(CLK_HZ)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .ir_in   (ir_in),
    .fall    (fall),
    .rise    (rise),
    .width_us(width_us)
  );

  nec_state_t  state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] ir_data_q, ir_data_d;
  logic        dr_q, dr_d, rr_q, rr_d, fe_q, fe_d;
  logic        any_edge;

  assign any_edge     = fall | rise;
  assign ir_data      = ir_data_q;
  assign data_ready   = dr_q;
  assign repeat_ready = rr_q;
  assign frame_error  = fe_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ir_data_d = ir_data_q;
    dr_d      = 1'b0;
    rr_d      = 1'b0;
    fe_d      = 1'b0;

    if ((state_q != IDLE) && !any_edge && (width_us > TIMEOUT_US)) begin
      state_d = IDLE;
      fe_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (fall) state_d = LEAD_LOW;
        end
        LEAD_LOW: begin
          // A leader burst of the wrong length is treated as noise.
          if (rise) begin
            state_d = in_window(width_us, LEAD_LOW_MIN, LEAD_LOW_MAX) ? LEAD_HIGH : IDLE;
          end
        end
        LEAD_HIGH: begin
          if (fall) begin
            if (in_window(width_us, LEAD_HIGH_MIN, LEAD_HIGH_MAX)) begin
              state_d   = BIT_LOW;
              bit_cnt_d = '0;
            end else if (in_window(width_us, REP_HIGH_MIN, REP_HIGH_MAX)) begin
              state_d = REP_STOP;
            end else begin
              state_d = IDLE;
              fe_d    = 1'b1;
            end
          end
        end
        BIT_LOW: begin
          if (rise) begin
            if (!in_window(width_us, BURST_MIN, BURST_MAX)) begin
              state_d = IDLE;
              fe_d    = 1'b1;
            end else if (bit_cnt_q != FRAME_BITS) begin
              state_d = BIT_HIGH;
            end else begin
              state_d = IDLE;
              if (shift_q[7:0] == ~shift_q[15:8]) begin
                ir_data_d = shift_q;
                dr_d      = 1'b1;
              end else begin
                fe_d = 1'b1;
              end
            end
          end
        end
        BIT_HIGH: begin
          if (fall) begin
            if (in_window(width_us, ZERO_MIN, ZERO_MAX)) begin
              shift_d   = {1'b0, shift_q[31:1]};
              bit_cnt_d = bit_cnt_q + 6'd1;
              state_d   = BIT_LOW;
            end else if (in_window(width_us, ONE_MIN, ONE_MAX)) begin
              shift_d   = {1'b1, shift_q[31:1]};
              bit_cnt_d = bit_cnt_q + 6'd1;
              state_d   = BIT_LOW;
            end else begin
              state_d = IDLE;
              fe_d    = 1'b1;
            end
          end
        end
        REP_STOP: begin
          if (rise) begin
            state_d = IDLE;
            if (in_window(width_us, BURST_MIN, BURST_MAX)) rr_d = 1'b1;
            else                                          fe_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ir_data_q <= '0;
      dr_q      <= 1'b0;
      rr_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ir_data_q <= ir_data_d;
      dr_q      <= dr_d;
      rr_q      <= rr_d;
      fe_q      <= fe_d;
    end
  end

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Directed bench for nec_ir_decoder at 1 MHz, so one clock equals one microsecond.
`timescale 1ns/1ps
module tb_nec_ir_decoder;
  import ir_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_in;
  logic [31:0] ir_data;
  logic        data_ready, repeat_ready, frame_error;

  int errors = 0;
  int checks = 0;

  int tot_dr = 0, tot_rr = 0, tot_fe = 0, tot_ovl = 0;
  logic [31:0] dr_data = '0;

  int t_burst = 400, t_zero = 400, t_one = 1400;

  always #5 clk = ~clk;

  nec_ir_decoder #(.CLK_HZ(1_000_000)) dut (
    .clk         (clk),
    .rst         (rst),
    .ir_in       (ir_in),
    .ir_data     (ir_data),
    .data_ready  (data_ready),
    .repeat_ready(repeat_ready),
    .frame_error (frame_error)
  );

  always @(negedge clk) begin
    if (data_ready) begin
      tot_dr  = tot_dr + 1;
      dr_data = ir_data;
    end
    if (repeat_ready) tot_rr = tot_rr + 1;
    if (frame_error)  tot_fe = tot_fe + 1;
    if ((int'(data_ready) + int'(repeat_ready) + int'(frame_error)) > 1) tot_ovl = tot_ovl + 1;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic level(input logic v, input int n);
    ir_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      level(1'b0, t_burst);
      level(1'b1, w[i] ? t_one : t_zero);
    end
  endtask

  // Waits a fixed 10 cycles and reports the cycle of the first strobe (-1 if none).
  task automatic wait_event(output int lat);
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if ((lat < 0) && (data_ready || repeat_ready || frame_error)) lat = c;
    end
  endtask

  task automatic send_frame(input logic [31:0] w, output int lat);
    level(1'b0, 8000);
    level(1'b1, 4000);
    send_bits(w, 32);
    level(1'b0, t_burst);
    ir_in = 1'b1;
    wait_event(lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ir_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ir_data !== 32'h0) begin errors++; $display("FAIL reset_ir_data: got %h expected %h", ir_data, 32'h0); end
    checks++; if ({data_ready, repeat_ready, frame_error} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {data_ready, repeat_ready, frame_error}); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_frame();
    int lat, b_dr, b_rr, b_fe;
    b_dr = tot_dr; b_rr = tot_rr; b_fe = tot_fe;
    send_frame(32'hFF00ED12, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL frame_latency: got %0d expected 3", lat); end
    checks++; if (tot_dr - b_dr !== 1) begin errors++; $display("FAIL frame_dr_count: got %0d expected 1", tot_dr - b_dr); end
    checks++; if ((tot_rr - b_rr) + (tot_fe - b_fe) !== 0) begin errors++; $display("FAIL frame_other_pulses: got %0d expected 0", (tot_rr - b_rr) + (tot_fe - b_fe)); end
    checks++; if (ir_data !== 32'hFF00ED12) begin errors++; $display("FAIL frame_ir_data: got %h expected %h", ir_data, 32'hFF00ED12); end
    checks++; if (dr_data !== 32'hFF00ED12) begin errors++; $display("FAIL frame_data_at_strobe: got %h expected %h", dr_data, 32'hFF00ED12); end
  endtask

  task automatic test_repeat();
    int lat, b_dr, b_rr, b_fe;
    b_dr = tot_dr; b_rr = tot_rr; b_fe = tot_fe;
    level(1'b0, 9000); level(1'b1, 2250); level(1'b0, 560);
    ir_in = 1'b1;
    wait_event(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL repeat_latency: got %0d expected 3", lat); end
    checks++; if (tot_rr - b_rr !== 1) begin errors++; $display("FAIL repeat_rr_count: got %0d expected 1", tot_rr - b_rr); end
    checks++; if ((tot_dr - b_dr) + (tot_fe - b_fe) !== 0) begin errors++; $display("FAIL repeat_other_pulses: got %0d expected 0", (tot_dr - b_dr) + (tot_fe - b_fe)); end
    checks++; if (ir_data !== 32'hFF00ED12) begin errors++; $display("FAIL repeat_ir_data_held: got %h expected %h", ir_data, 32'hFF00ED12); end
    // Inclusive window edges, minimum then maximum.
    b_rr = tot_rr;
    level(1'b0, 8000); level(1'b1, 2000); level(1'b0, 400); ir_in = 1'b1; wait_event(lat);
    level(1'b0, 10000); level(1'b1, 2500); level(1'b0, 700); ir_in = 1'b1; wait_event(lat);
    checks++; if (tot_rr - b_rr !== 2) begin errors++; $display("FAIL repeat_boundaries_accepted: got %0d expected 2", tot_rr - b_rr); end
    b_fe = tot_fe; b_rr = tot_rr;
    level(1'b0, 8000); level(1'b1, 1999); ir_in = 1'b0; wait_event(lat); level(1'b0, 550); level(1'b1, 50);
    level(1'b0, 8000); level(1'b1, 2501); ir_in = 1'b0; wait_event(lat); level(1'b0, 550); level(1'b1, 50);
    checks++; if (tot_fe - b_fe !== 2) begin errors++; $display("FAIL repeat_high_outside: got %0d expected 2", tot_fe - b_fe); end
    checks++; if (tot_rr - b_rr !== 0) begin errors++; $display("FAIL repeat_high_outside_rr: got %0d expected 0", tot_rr - b_rr); end
  endtask

  task automatic test_bad_inverse();
    int lat, b_dr, b_fe;
    b_dr = tot_dr; b_fe = tot_fe;
    send_frame(32'hFF00E51B, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL badinv_latency: got %0d expected 3", lat); end
    checks++; if (tot_fe - b_fe !== 1) begin errors++; $display("FAIL badinv_fe_count: got %0d expected 1", tot_fe - b_fe); end
    checks++; if (tot_dr - b_dr !== 0) begin errors++; $display("FAIL badinv_dr_count: got %0d expected 0", tot_dr - b_dr); end
    checks++; if (ir_data !== 32'hFF00ED12) begin errors++; $display("FAIL badinv_ir_data_held: got %h expected %h", ir_data, 32'hFF00ED12); end
  endtask

  task automatic test_glitch();
    int b_all;
    b_all = tot_dr + tot_rr + tot_fe;
    level(1'b0, 6000); level(1'b1, 200);
    level(1'b0, 7999); level(1'b1, 200);
    checks++; if (tot_dr + tot_rr + tot_fe - b_all !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", tot_dr + tot_rr + tot_fe - b_all); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_bit_high_error();
    int lat, b_dr, b_fe;
    b_dr = tot_dr; b_fe = tot_fe;
    level(1'b0, 8000); level(1'b1, 4000);
    send_bits(32'hFF00ED12, 10);
    level(1'b0, t_burst); level(1'b1, 3000);
    ir_in = 1'b0;
    wait_event(lat);
    level(1'b0, 390); level(1'b1, 50);
    checks++; if (lat !== 3) begin errors++; $display("FAIL bit10_latency: got %0d expected 3", lat); end
    checks++; if (tot_fe - b_fe !== 1) begin errors++; $display("FAIL bit10_fe_count: got %0d expected 1", tot_fe - b_fe); end
    checks++; if (tot_dr - b_dr !== 0) begin errors++; $display("FAIL bit10_dr_count: got %0d expected 0", tot_dr - b_dr); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL bit10_state: got %0d expected %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_timeout();
    int b_fe;
    b_fe = tot_fe;
    level(1'b0, 8000); level(1'b1, 4000); level(1'b0, t_burst);
    level(1'b1, 9990);
    checks++; if (tot_fe - b_fe !== 0) begin errors++; $display("FAIL timeout_early: got %0d expected 0", tot_fe - b_fe); end
    level(1'b1, 40);
    checks++; if (tot_fe - b_fe !== 1) begin errors++; $display("FAIL timeout_high: got %0d expected 1", tot_fe - b_fe); end
    level(1'b0, 10100); level(1'b1, 50);
    checks++; if (tot_fe - b_fe !== 2) begin errors++; $display("FAIL timeout_stuck_low: got %0d expected 2", tot_fe - b_fe); end
  endtask

  task automatic test_boundaries();
    int lat, b_fe;
    b_fe = tot_fe;
    level(1'b0, 8000); level(1'b1, 3999); ir_in = 1'b0; wait_event(lat); level(1'b0, 390); level(1'b1, 50);
    checks++; if (tot_fe - b_fe !== 1) begin errors++; $display("FAIL lead_high_3999: got %0d expected 1", tot_fe - b_fe); end
    // Leader at 10000/5000 is accepted; the 399 us burst that follows is not.
    level(1'b0, 10000); level(1'b1, 5000); ir_in = 1'b0; wait_event(lat);
    checks++; if (lat !== -1) begin errors++; $display("FAIL lead_max_accepted: got %0d expected -1", lat); end
    level(1'b0, 389); ir_in = 1'b1; wait_event(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL burst_399: got %0d expected 3", lat); end
    t_burst = 700; t_zero = 700; t_one = 1900;
    b_fe = tot_fe;
    level(1'b0, 8000); level(1'b1, 4000);
    send_bits(32'h0000_0005, 3);
    checks++; if (tot_fe - b_fe !== 0) begin errors++; $display("FAIL bit_max_accepted: got %0d expected 0", tot_fe - b_fe); end
    level(1'b0, 700); level(1'b1, 701); ir_in = 1'b0; wait_event(lat); level(1'b0, 390); level(1'b1, 50);
    checks++; if (tot_fe - b_fe !== 1) begin errors++; $display("FAIL bit_high_701: got %0d expected 1", tot_fe - b_fe); end
    t_burst = 400; t_zero = 400; t_one = 1400;
    level(1'b0, 8000); level(1'b1, 4000); level(1'b0, 400); level(1'b1, 1399);
    ir_in = 1'b0; wait_event(lat); level(1'b0, 390); level(1'b1, 50);
    checks++; if (tot_fe - b_fe !== 2) begin errors++; $display("FAIL bit_high_1399: got %0d expected 2", tot_fe - b_fe); end
    level(1'b0, 8000); level(1'b1, 4000); level(1'b0, 701); ir_in = 1'b1; wait_event(lat);
    checks++; if (tot_fe - b_fe !== 3) begin errors++; $display("FAIL burst_701: got %0d expected 3", tot_fe - b_fe); end
    checks++; if (tot_ovl !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", tot_ovl); end
  endtask

  task automatic test_reset_midframe();
    int lat, b_dr, b_all;
    level(1'b0, 8000); level(1'b1, 4000);
    send_bits(32'hFF00E41B, 15);
    level(1'b0, t_burst); level(1'b1, 200);
    rst = 1'b1;
    #1;
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL midrst_state: got %0d expected %0d", dut.state_q, IDLE); end
    checks++; if (dut.bit_cnt_q !== 6'd0) begin errors++; $display("FAIL midrst_bit_cnt: got %0d expected 0", dut.bit_cnt_q); end
    checks++; if (dut.shift_q !== 32'h0) begin errors++; $display("FAIL midrst_shift: got %h expected %h", dut.shift_q, 32'h0); end
    @(negedge clk);
    rst = 1'b0;
    b_all = tot_dr + tot_rr + tot_fe;
    level(1'b1, 2000);
    checks++; if (tot_dr + tot_rr + tot_fe - b_all !== 0) begin errors++; $display("FAIL midrst_pulses: got %0d expected 0", tot_dr + tot_rr + tot_fe - b_all); end
    checks++; if (ir_data !== 32'h0) begin errors++; $display("FAIL midrst_ir_data: got %h expected %h", ir_data, 32'h0); end
    b_dr = tot_dr; b_all = tot_rr + tot_fe;
    send_frame(32'hFF00E41B, lat);
    checks++; if (tot_dr - b_dr !== 1) begin errors++; $display("FAIL midrst_frame_dr: got %0d expected 1", tot_dr - b_dr); end
    checks++; if (tot_rr + tot_fe - b_all !== 0) begin errors++; $display("FAIL midrst_frame_other: got %0d expected 0", tot_rr + tot_fe - b_all); end
    checks++; if (ir_data !== 32'hFF00E41B) begin errors++; $display("FAIL midrst_frame_ir_data: got %h expected %h", ir_data, 32'hFF00E41B); end
  endtask

  initial begin
    rst = 1'b1;
    ir_in = 1'b1;
    @(negedge clk);
    test_reset();
    test_frame();
    test_repeat();
    test_bad_inverse();
    test_glitch();
    test_bit_high_error();
    test_timeout();
    test_boundaries();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
